// File: rtl/sum_window_accumulator.sv
// ---------------------------------------------------------------------------
// sum_window_accumulator
//
// Collects a fixed window of 2**WIN_LOG2 unsigned sums from the adder stage
// over a valid/ready handshake. When the last sample of a window arrives it
// registers the window total, its floor average and its maximum, and holds
// them on a valid/ready output handshake until the downstream stage takes
// them. The block takes no new samples while a result is pending.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   in_sum carries a sample this cycle
//   in_ready   block can take a sample this cycle (combinational)
//   in_sum     unsigned sample, SUM_W bits
//   out_valid  window result valid (registered)
//   out_ready  downstream takes the result this cycle
//   out_total  sum of the window's samples, ACC_W bits (registered)
//   out_avg    out_total >> WIN_LOG2, floor (registered)
//   out_max    largest sample in the window (registered)
//   count      samples taken so far in the current window (registered)
// ---------------------------------------------------------------------------
module sum_window_accumulator #(
  parameter int SUM_W    = 5,
  parameter int WIN_LOG2 = 3,
  // Must stay >= SUM_W + WIN_LOG2 so the window total can never wrap.
  parameter int ACC_W    = SUM_W + WIN_LOG2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SUM_W-1:0]    in_sum,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ACC_W-1:0]    out_total,
  output logic [SUM_W-1:0]    out_avg,
  output logic [SUM_W-1:0]    out_max,
  output logic [WIN_LOG2-1:0] count
);

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [WIN_LOG2-1:0]   cnt_q, cnt_d;
  logic [SUM_W-1:0]      max_q, max_d;
  logic                  out_valid_q, out_valid_d;
  logic [ACC_W-1:0]      out_total_q, out_total_d;
  logic [SUM_W-1:0]      out_avg_q, out_avg_d;
  logic [SUM_W-1:0]      out_max_q, out_max_d;

  logic                  accept;
  logic                  last_sample;
  logic [ACC_W-1:0]      sum_full;
  logic [SUM_W-1:0]      max_new;

  assign accept      = in_valid & in_ready;
  // cnt saturating at all-ones marks the final sample of the window.
  assign last_sample = (cnt_q == '1);
  assign sum_full    = acc_q + ACC_W'(in_sum);
  assign max_new     = (in_sum > max_q) ? in_sum : max_q;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  // NOTE: registers are updated with non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_ACCUM: if (accept && last_sample) state_d = ST_HOLD;
      ST_HOLD:  if (out_ready)             state_d = ST_ACCUM;
      default:                             state_d = ST_ACCUM;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  // in_ready is low in reset and for the whole HOLD state, including the
  // cycle in which out_ready releases the result.
  always_comb begin
    in_ready = (state_q == ST_ACCUM) && !rst;
  end

  // -------------------------------------------------------------------------
  // Datapath next state
  // -------------------------------------------------------------------------
  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    max_d       = max_q;
    out_valid_d = out_valid_q;
    out_total_d = out_total_q;
    out_avg_d   = out_avg_q;
    out_max_d   = out_max_q;

    if (accept) begin
      if (last_sample) begin
        out_total_d = sum_full;
        out_avg_d   = SUM_W'(sum_full >> WIN_LOG2);
        out_max_d   = max_new;
        out_valid_d = 1'b1;
        acc_d       = '0;
        cnt_d       = '0;
        max_d       = '0;
      end else begin
        acc_d = sum_full;
        cnt_d = cnt_q + 1'b1;
        max_d = max_new;
      end
    end

    // out_ready only matters while a result is pending.
    if (state_q == ST_HOLD && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      max_q       <= '0;
      out_valid_q <= 1'b0;
      out_total_q <= '0;
      out_avg_q   <= '0;
      out_max_q   <= '0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      max_q       <= max_d;
      out_valid_q <= out_valid_d;
      out_total_q <= out_total_d;
      out_avg_q   <= out_avg_d;
      out_max_q   <= out_max_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_total = out_total_q;
  assign out_avg   = out_avg_q;
  assign out_max   = out_max_q;
  assign count     = cnt_q;

endmodule

// File: tb/tb_sum_window_accumulator.sv
// ---------------------------------------------------------------------------
// Testbench for sum_window_accumulator (default parameters: 5-bit sums,
// 8-sample windows, 8-bit total). Inputs change 1 ns after the rising edge
// and outputs are compared 1 ns after that, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_sum_window_accumulator;

  localparam int SUM_W    = 5;
  localparam int WIN_LOG2 = 3;
  localparam int ACC_W    = SUM_W + WIN_LOG2;

  logic                clk;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [SUM_W-1:0]    in_sum;
  logic                out_valid;
  logic                out_ready;
  logic [ACC_W-1:0]    out_total;
  logic [SUM_W-1:0]    out_avg;
  logic [SUM_W-1:0]    out_max;
  logic [WIN_LOG2-1:0] count;

  int n_checks = 0;
  int n_fail   = 0;

  sum_window_accumulator #(
    .SUM_W   (SUM_W),
    .WIN_LOG2(WIN_LOG2),
    .ACC_W   (ACC_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sum   (in_sum),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_total(out_total),
    .out_avg  (out_avg),
    .out_max  (out_max),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One stimulus/response record per clock cycle.
  typedef struct {
    logic             rst;
    logic             iv;
    logic [SUM_W-1:0] sum;
    logic             ordy;
    logic             e_rdy;
    logic             e_ov;
    logic [ACC_W-1:0] e_tot;
    logic [SUM_W-1:0] e_avg;
    logic [SUM_W-1:0] e_max;
    logic [WIN_LOG2-1:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply inputs and let combinational outputs settle.
  task automatic drive(input logic r, input logic iv, input int s, input logic ordy);
    rst       = r;
    in_valid  = iv;
    in_sum    = SUM_W'(s);
    out_ready = ordy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic rdy, input logic ov,
                         input int tot, input int avg, input int mx, input int cnt);
    check({tag, " in_ready"},  32'(in_ready),  32'(rdy));
    check({tag, " out_valid"}, 32'(out_valid), 32'(ov));
    check({tag, " out_total"}, 32'(out_total), 32'(tot));
    check({tag, " out_avg"},   32'(out_avg),   32'(avg));
    check({tag, " out_max"},   32'(out_max),   32'(mx));
    check({tag, " count"},     32'(count),     32'(cnt));
  endtask

  function automatic void add(input logic r, input logic iv, input int s,
                              input logic ordy, input logic e_rdy, input logic e_ov,
                              input int tot, input int avg, input int mx, input int cnt);
    vec_t v;
    v.rst = r;  v.iv = iv;  v.sum = SUM_W'(s);  v.ordy = ordy;
    v.e_rdy = e_rdy;  v.e_ov = e_ov;
    v.e_tot = ACC_W'(tot);  v.e_avg = SUM_W'(avg);  v.e_max = SUM_W'(mx);
    v.e_cnt = WIN_LOG2'(cnt);
    vecs.push_back(v);
  endfunction

  initial begin
    int gaps[7];
    int i_smp;
    int sum_s;
    int max_s;
    int v;

    // ---------------- Reset state ----------------
    drive(1, 0, 0, 0);
    tick();
    tick();
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0);
    check("reset release in_ready", 32'(in_ready), 32'd1);

    // ---------------- Table: tests 1 and 2 ----------------
    // Test 1: eight samples of 30.
    for (int k = 0; k < 8; k++) add(0, 1, 30, 1, 1, 0, 0, 0, 0, k);
    add(0, 1, 30, 1, 0, 1, 240, 30, 30, 0);   // result, consumed this cycle
    add(0, 0, 0,  1, 1, 0, 240, 30, 30, 0);   // out_valid low, in_ready back

    // Test 2: samples 0..7 with idle gaps; stale result stays visible.
    gaps = '{1, 2, 3, 1, 2, 1, 3};
    for (int k = 0; k < 8; k++) begin
      add(0, 1, k, 0, 1, 0, 240, 30, 30, k);
      if (k < 7)
        for (int g = 0; g < gaps[k]; g++) add(0, 0, 31, 0, 1, 0, 240, 30, 30, k + 1);
    end
    add(0, 0, 31, 1, 0, 1, 28, 3, 7, 0);
    add(0, 0, 31, 0, 1, 0, 28, 3, 7, 0);

    foreach (vecs[n]) begin
      drive(vecs[n].rst, vecs[n].iv, int'(vecs[n].sum), vecs[n].ordy);
      chk_all($sformatf("vec%0d", n), vecs[n].e_rdy, vecs[n].e_ov, int'(vecs[n].e_tot),
              int'(vecs[n].e_avg), int'(vecs[n].e_max), int'(vecs[n].e_cnt));
      tick();
    end

    // ---------------- Test 3: backpressure ----------------
    begin
      int smp[8];
      smp = '{5, 9, 0, 30, 1, 1, 1, 1};
      for (int k = 0; k < 8; k++) begin
        drive(0, 1, smp[k], 0);
        check($sformatf("bp acc%0d in_ready", k), 32'(in_ready), 32'd1);
        check($sformatf("bp acc%0d count", k), 32'(count), 32'(k));
        tick();
      end
    end
    for (int k = 0; k < 6; k++) begin
      drive(0, 1, (k % 2) ? 17 : 3, 0);
      chk_all($sformatf("bp hold%0d", k), 0, 1, 48, 6, 30, 0);
      tick();
    end
    drive(0, 1, 17, 1);
    chk_all("bp release", 0, 1, 48, 6, 30, 0);
    tick();
    // First sample of the next window is the one presented once in_ready rises.
    for (int k = 0; k < 8; k++) begin
      drive(0, 1, 4, 0);
      check($sformatf("bp next%0d in_ready", k), 32'(in_ready), 32'd1);
      check($sformatf("bp next%0d count", k), 32'(count), 32'(k));
      tick();
    end
    drive(0, 0, 0, 1);
    chk_all("bp next result", 0, 1, 32, 4, 4, 0);
    tick();

    // ---------------- Test 4: reset mid-window ----------------
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 20, 0);
      tick();
    end
    drive(1, 1, 20, 0);
    check("mid rst in_ready", 32'(in_ready), 32'd0);
    check("mid rst count before", 32'(count), 32'd3);
    tick();
    drive(0, 0, 0, 0);
    chk_all("mid rst after", 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      drive(0, 1, 2, 0);
      tick();
    end
    drive(0, 0, 0, 1);
    chk_all("mid rst window", 0, 1, 16, 2, 2, 0);
    tick();

    // ---------------- Test 6: reset during HOLD ----------------
    for (int k = 0; k < 8; k++) begin
      drive(0, 1, 10, 0);
      tick();
    end
    drive(0, 0, 0, 0);
    chk_all("hold pending", 0, 1, 80, 10, 10, 0);
    drive(1, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0);
    chk_all("hold rst after", 1, 0, 0, 0, 0, 0);
    tick();

    // ---------------- Test 5: back-to-back windows ----------------
    i_smp = 0;
    for (int w = 0; w < 4; w++) begin
      sum_s = 0;
      max_s = 0;
      for (int c = 0; c < 8; c++) begin
        v = i_smp % 31;
        drive(0, 1, v, 1);
        check($sformatf("b2b w%0d c%0d in_ready", w, c), 32'(in_ready), 32'd1);
        check($sformatf("b2b w%0d c%0d out_valid", w, c), 32'(out_valid), 32'd0);
        check($sformatf("b2b w%0d c%0d count", w, c), 32'(count), 32'(c));
        sum_s += v;
        if (v > max_s) max_s = v;
        i_smp++;
        tick();
      end
      drive(0, 1, i_smp % 31, 1);
      chk_all($sformatf("b2b w%0d result", w), 0, 1, sum_s, sum_s >> WIN_LOG2, max_s, 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
